// File: rtl/seg_page_scheduler_pkg.sv
// Shared constants and types for the 7-seg page scheduler.
// Segment bit order (active-low): {dp, a, f, b, g, e, d, c}.
package seg_page_scheduler_pkg;

    localparam int NUM_PAGES = 4;

    localparam logic [7:0] SEG_0 = 8'b1000_1000;
    localparam logic [7:0] SEG_1 = 8'b1110_1110;
    localparam logic [7:0] SEG_2 = 8'b1010_0001;
    localparam logic [7:0] SEG_3 = 8'b1010_0100;
    localparam logic [7:0] SEG_4 = 8'b1100_0110;
    localparam logic [7:0] SEG_5 = 8'b1001_0100;
    localparam logic [7:0] SEG_6 = 8'b1001_0000;
    localparam logic [7:0] SEG_7 = 8'b1010_1110;
    localparam logic [7:0] SEG_8 = 8'b1000_0000;
    localparam logic [7:0] SEG_9 = 8'b1000_0100;
    localparam logic [7:0] SEG_A = 8'b1000_0010;
    localparam logic [7:0] SEG_B = 8'b1101_0000;
    localparam logic [7:0] SEG_C = 8'b1001_1001;
    localparam logic [7:0] SEG_D = 8'b1110_0000;
    localparam logic [7:0] SEG_E = 8'b1001_0001;
    localparam logic [7:0] SEG_F = 8'b1001_0011;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEL_NONE  = 8'hFF;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } scan_state_t;

endpackage

// File: rtl/seg_page_scheduler_if.sv
// Debug-page inputs and display pin outputs of the page scheduler.
interface seg_page_scheduler_if;
    logic [127:0] page_data;
    logic [3:0]   page_valid;
    logic         auto_en;
    logic         next_req;
    logic [7:0]   dp_mask;
    logic [7:0]   LEDSEL;
    logic [7:0]   LEDOUT;
    logic [1:0]   page_idx;
    logic         page_tick;

    modport master (
        output page_data, page_valid, auto_en, next_req, dp_mask,
        input  LEDSEL, LEDOUT, page_idx, page_tick
    );

    modport slave (
        input  page_data, page_valid, auto_en, next_req, dp_mask,
        output LEDSEL, LEDOUT, page_idx, page_tick
    );
endinterface

// File: rtl/seg_page_scheduler_hex_to_seg.sv
// Nibble to active-low 7-seg pattern, decimal point off.
module hex_to_seg
    import seg_page_scheduler_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_BLANK;
        endcase
    end
endmodule

// File: rtl/seg_page_scheduler.sv
// Time-shares the 8-digit 7-seg display between up to 4 debug pages,
// with anti-ghosting blank gaps and frame-aligned page switching.
module seg_page_scheduler
    import seg_page_scheduler_pkg::*;
#(
    parameter int SCAN_DIV  = 10000,
    parameter int BLANK_CYC = 500,
    parameter int DWELL_DIV = 100000000
) (
    input logic clk100MHz,
    input logic rst,
    seg_page_scheduler_if.slave bus
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DWELL_DIV);
    localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYC - 1);
    localparam logic [SW-1:0] DRIVE_LAST = SW'(SCAN_DIV - BLANK_CYC - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_DIV - 1);

    scan_state_t   state;
    logic [SW-1:0] slot_cnt;
    logic [2:0]    digit;
    logic [31:0]   snap;
    logic          snap_on;
    logic [DW-1:0] dwell_cnt;
    logic          pending;

    logic [3:0]  nibble;
    logic [7:0]  seg_raw;
    logic [7:0]  drive_seg;
    logic [7:0]  drive_sel;
    logic        frame_end;
    logic        dwell_hit;
    logic        advance;
    logic        change;
    logic [2:0]  next_found;
    logic [1:0]  new_idx;

    // Round-robin search for the next valid page after cur, excluding cur.
    function automatic logic [2:0] find_next(input logic [1:0] cur, input logic [3:0] vld);
        logic [1:0] cand;
        logic [2:0] res;
        res = 3'b000;
        for (int i = 1; i < NUM_PAGES; i++) begin
            cand = cur + 2'(i);
            if (vld[cand] && !res[2]) res = {1'b1, cand};
        end
        return res;
    endfunction

    assign nibble    = snap[{digit, 2'b00} +: 4];
    assign drive_seg = {seg_raw[7] & ~bus.dp_mask[digit], seg_raw[6:0]};
    assign drive_sel = ~(8'b1 << digit);

    hex_to_seg u_hex (.nibble(nibble), .seg(seg_raw));

    assign frame_end  = (state == ST_DRIVE) && (slot_cnt == DRIVE_LAST) && (digit == 3'd7);
    assign dwell_hit  = bus.auto_en && (dwell_cnt == DWELL_LAST);
    assign advance    = pending || bus.next_req || dwell_hit;
    assign next_found = find_next(bus.page_idx, bus.page_valid);
    assign change     = frame_end && next_found[2] && (advance || !bus.page_valid[bus.page_idx]);
    assign new_idx    = change ? next_found[1:0] : bus.page_idx;

    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            state      <= ST_BLANK;
            slot_cnt   <= '0;
            digit      <= 3'd0;
            bus.LEDSEL <= SEL_NONE;
            bus.LEDOUT <= SEG_BLANK;
        end else begin
            case (state)
                ST_BLANK: begin
                    if (slot_cnt == BLANK_LAST) begin
                        state      <= ST_DRIVE;
                        slot_cnt   <= '0;
                        bus.LEDSEL <= snap_on ? drive_sel : SEL_NONE;
                        bus.LEDOUT <= snap_on ? drive_seg : SEG_BLANK;
                    end else begin
                        slot_cnt   <= slot_cnt + SW'(1);
                        bus.LEDSEL <= SEL_NONE;
                        bus.LEDOUT <= SEG_BLANK;
                    end
                end
                ST_DRIVE: begin
                    if (slot_cnt == DRIVE_LAST) begin
                        state      <= ST_BLANK;
                        slot_cnt   <= '0;
                        digit      <= digit + 3'd1;
                        bus.LEDSEL <= SEL_NONE;
                        bus.LEDOUT <= SEG_BLANK;
                    end else begin
                        slot_cnt   <= slot_cnt + SW'(1);
                        bus.LEDSEL <= snap_on ? drive_sel : SEL_NONE;
                        bus.LEDOUT <= snap_on ? drive_seg : SEG_BLANK;
                    end
                end
                default: state <= ST_BLANK;
            endcase
        end
    end

    // Page selection, snapshot and advance bookkeeping; all changes land on frame_end.
    always_ff @(posedge clk100MHz) begin
        if (rst) begin
            bus.page_idx  <= 2'd0;
            bus.page_tick <= 1'b0;
            dwell_cnt     <= '0;
            pending       <= 1'b0;
            snap          <= bus.page_data[31:0];
            snap_on       <= |bus.page_valid;
        end else begin
            bus.page_tick <= change;
            if (frame_end) begin
                pending      <= 1'b0;
                bus.page_idx <= new_idx;
                snap         <= bus.page_data[{new_idx, 5'b0} +: 32];
                snap_on      <= |bus.page_valid;
            end else if (bus.next_req || dwell_hit) begin
                pending <= 1'b1;
            end

            if (!bus.auto_en || change || dwell_hit) dwell_cnt <= '0;
            else                                     dwell_cnt <= dwell_cnt + DW'(1);
        end
    end
endmodule

// File: tb/tb_seg_page_scheduler.sv
// Scoreboard bench for seg_page_scheduler: stimulus queues expected display
// samples and page ticks; a negedge monitor pops and compares them.
module tb_seg_page_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg_page_scheduler_if bus ();

    seg_page_scheduler #(.SCAN_DIV(8), .BLANK_CYC(2), .DWELL_DIV(200)) dut (
        .clk100MHz(clk),
        .rst      (rst),
        .bus      (bus)
    );

    typedef struct {
        int         cyc;
        logic [7:0] sel;
        logic [7:0] out;
        logic [1:0] idx;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [1:0] idx;
    } tick_t;

    exp_t  exp_q[$];
    tick_t tick_q[$];

    int  tcyc = 0;
    int  base = 0;
    int  checks = 0;
    int  errors = 0;
    bit  done = 1'b0;
    bit  drained = 1'b0;

    // Hand-derived patterns, order {dp,a,f,b,g,e,d,c}, active-low.
    logic [7:0] seg_tab [16] = '{
        8'b1000_1000, 8'b1110_1110, 8'b1010_0001, 8'b1010_0100,
        8'b1100_0110, 8'b1001_0100, 8'b1001_0000, 8'b1010_1110,
        8'b1000_0000, 8'b1000_0100, 8'b1000_0010, 8'b1101_0000,
        8'b1001_1001, 8'b1110_0000, 8'b1001_0001, 8'b1001_0011
    };

    always @(posedge clk) tcyc <= tcyc + 1;

    always @(negedge clk) begin
        exp_t  e;
        tick_t t;
        while (exp_q.size() > 0 && exp_q[0].cyc < tcyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_sample abs=%0d now=%0d", e.cyc, tcyc);
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == tcyc) begin
            e = exp_q.pop_front();
            checks++;
            if (bus.LEDSEL !== e.sel || bus.LEDOUT !== e.out || bus.page_idx !== e.idx) begin
                errors++;
                $display("FAIL display rel=%0d got sel=%h out=%h idx=%0d want sel=%h out=%h idx=%0d",
                         tcyc - base, bus.LEDSEL, bus.LEDOUT, bus.page_idx, e.sel, e.out, e.idx);
            end
        end
        if (bus.page_tick !== 1'b0) begin
            checks++;
            if (tick_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_tick rel=%0d idx=%0d", tcyc - base, bus.page_idx);
            end else begin
                t = tick_q.pop_front();
                if (t.cyc != tcyc || bus.page_idx !== t.idx) begin
                    errors++;
                    $display("FAIL page_tick got rel=%0d idx=%0d want rel=%0d idx=%0d",
                             tcyc - base, bus.page_idx, t.cyc - base, t.idx);
                end
            end
        end
        if (done && !drained) begin
            drained = 1'b1;
            foreach (exp_q[i]) begin
                checks++;
                errors++;
                $display("FAIL unchecked_sample abs=%0d", exp_q[i].cyc);
            end
            foreach (tick_q[i]) begin
                checks++;
                errors++;
                $display("FAIL missing_tick rel=%0d want idx=%0d", tick_q[i].cyc - base, tick_q[i].idx);
            end
        end
    end

    task automatic push_exp(input int rel, input logic [7:0] s, input logic [7:0] o, input logic [1:0] i);
        exp_q.push_back('{base + rel, s, o, i});
    endtask

    task automatic push_tick(input int rel, input logic [1:0] i);
        tick_q.push_back('{base + rel, i});
    endtask

    // One full 64-cycle frame: 2 blank cycles then 6 drive cycles per digit.
    task automatic push_frame(input int rel0, input logic [31:0] w, input logic [7:0] dp,
                              input bit on, input logic [1:0] i);
        logic [7:0] one;
        logic [7:0] o;
        one = 8'b1;
        for (int d = 0; d < 8; d++) begin
            for (int c = 0; c < 8; c++) begin
                if (c < 2 || !on) begin
                    push_exp(rel0 + 8*d + c, 8'hFF, 8'hFF, i);
                end else begin
                    o = seg_tab[w[4*d +: 4]];
                    if (dp[d]) o[7] = 1'b0;
                    push_exp(rel0 + 8*d + c, ~(one << d), o, i);
                end
            end
        end
    endtask

    task automatic wait_rel(input int n);
        while (tcyc - base < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_next(input int rel);
        wait_rel(rel);
        bus.next_req = 1'b1;
        @(posedge clk);
        #1;
        bus.next_req = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        base = tcyc;
    endtask

    initial begin
        bus.page_data  = '0;
        bus.page_valid = 4'b0001;
        bus.auto_en    = 1'b0;
        bus.next_req   = 1'b0;
        bus.dp_mask    = 8'h00;
        @(posedge clk);
        #1;

        // Scan, decimal point, coherence, single valid page ignores next_req.
        bus.page_data[31:0] = 32'h89AB_CDEF;
        do_reset();
        push_frame(0,   32'h89AB_CDEF, 8'h00, 1'b1, 2'd0);
        push_frame(64,  32'h89AB_CDEF, 8'h01, 1'b1, 2'd0);
        push_frame(128, 32'h0123_4567, 8'h01, 1'b1, 2'd0);
        pulse_next(30);
        wait_rel(60);
        bus.dp_mask = 8'h01;
        wait_rel(80);
        bus.page_data[31:0] = 32'h0123_4567;
        wait_rel(192);

        // Round-robin with page 2 invalid.
        bus.dp_mask    = 8'h00;
        bus.page_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h89AB_CDEF};
        bus.page_valid = 4'b1011;
        do_reset();
        push_exp(63,  8'h7F, seg_tab[8],  2'd0);
        push_exp(64,  8'hFF, 8'hFF,       2'd1);
        push_exp(66,  8'hFE, seg_tab[1],  2'd1);
        push_exp(130, 8'hFE, seg_tab[3],  2'd3);
        push_exp(194, 8'hFE, seg_tab[15], 2'd0);
        push_exp(258, 8'hFE, seg_tab[15], 2'd0);
        push_tick(64,  2'd1);
        push_tick(128, 2'd3);
        push_tick(192, 2'd0);
        pulse_next(20);
        pulse_next(100);
        pulse_next(150);
        pulse_next(160);
        wait_rel(260);

        // No valid pages: dark display, no page changes.
        bus.page_valid = 4'b0000;
        do_reset();
        push_frame(0,   32'h0, 8'h00, 1'b0, 2'd0);
        push_frame(64,  32'h0, 8'h00, 1'b0, 2'd0);
        push_frame(128, 32'h0, 8'h00, 1'b0, 2'd0);
        pulse_next(10);
        wait_rel(192);

        // Auto dwell with two pages; next_req coincident with expiry at 711.
        bus.page_data[63:32] = 32'h7654_3210;
        bus.page_valid = 4'b0011;
        bus.auto_en    = 1'b1;
        do_reset();
        push_exp(258, 8'hFE, seg_tab[0],  2'd1);
        push_exp(514, 8'hFE, seg_tab[15], 2'd0);
        push_exp(770, 8'hFE, seg_tab[0],  2'd1);
        push_exp(922, 8'hF7, seg_tab[3],  2'd1);
        push_tick(256, 2'd0 + 2'd1);
        push_tick(512, 2'd0);
        push_tick(768, 2'd1);
        pulse_next(711);
        wait_rel(922);

        // Reset mid-drive of digit 3.
        do_reset();
        push_exp(0,  8'hFF, 8'hFF,       2'd0);
        push_exp(1,  8'hFF, 8'hFF,       2'd0);
        push_exp(2,  8'hFE, seg_tab[15], 2'd0);
        push_exp(7,  8'hFE, seg_tab[15], 2'd0);
        push_exp(8,  8'hFF, 8'hFF,       2'd0);
        push_exp(10, 8'hFD, seg_tab[14], 2'd0);
        wait_rel(20);

        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
